// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and control-field layout for the elastic pipeline stages.
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipeState_e;
    localparam int CTRL_W_DEFAULT   = 4;
    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_RESULTSRC   = 1;
    localparam int CTRL_RESULTSRC_W = 2;
    localparam int CTRL_MEMWRITE    = 3;
    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one payload+control holding register; clearing control turns the entry into a bubble.
module pipe_skid_entry #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clearCtrl,
    input  logic [DATA_W-1:0] nextData,
    input  logic [CTRL_W-1:0] nextCtrl,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            data <= '0;
            ctrl <= '0;
        end else if (clearCtrl) begin
            ctrl <= '0;
        end else if (load) begin
            data <= nextData;
            ctrl <= nextCtrl;
        end
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with optional 2-entry skid, flush-to-bubble
// and a saturating stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    pipeState_e state, stateNext;
    logic inFire, outFire, loadMain, loadSkid, mainFromSkid;
    logic [DATA_W-1:0] mainData, skidData;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;

    assign out_valid = state != ST_EMPTY;
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign out_data  = mainData;
    assign out_ctrl  = out_valid ? mainCtrl : '0;

    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        if (flush) begin
            stateNext = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    stateNext = inFire ? ST_ONE : ST_EMPTY;
                    loadMain  = inFire;
                end
                ST_ONE: begin
                    loadMain = inFire & outFire;
                    loadSkid = inFire & !outFire & (SKID != 0);
                    stateNext = loadSkid ? ST_TWO : (!inFire && outFire) ? ST_EMPTY : ST_ONE;
                end
                ST_TWO: begin
                    stateNext    = outFire ? ST_ONE : ST_TWO;
                    loadMain     = outFire;
                    mainFromSkid = outFire;
                end
                default: stateNext = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= ST_EMPTY;
        else        state <= stateNext;

    pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) mainEntry (
        .clk      (clk),
        .reset    (reset),
        .load     (loadMain),
        .clearCtrl(flush),
        .nextData (mainFromSkid ? skidData : in_data),
        .nextCtrl (mainFromSkid ? skidCtrl : in_ctrl),
        .data     (mainData),
        .ctrl     (mainCtrl)
    );

    generate
        if (SKID != 0) begin : gSkid
            logic readyReg;
            // Registered ready breaks the out_ready -> in_ready timing path between stages.
            always_ff @(posedge clk or negedge reset)
                if (!reset) readyReg <= 1'b1;
                else        readyReg <= stateNext != ST_TWO;
            assign in_ready = readyReg;
            pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skidEntry (
                .clk      (clk),
                .reset    (reset),
                .load     (loadSkid),
                .clearCtrl(flush),
                .nextData (in_data),
                .nextCtrl (in_ctrl),
                .data     (skidData),
                .ctrl     (skidCtrl)
            );
        end else begin : gNoSkid
            assign in_ready = out_ready | ~out_valid;
            assign skidData = '0;
            assign skidCtrl = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset)
        if (!reset) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: three stage variants on shared stimulus, each compared against a FIFO-queue model.
module tb_pipe_stage_elastic;
    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0] in_ctrl = '0;
    always #5 clk = ~clk;

    logic ovA, ovS, ovZ, irA, irS, irZ;
    logic [31:0] odA, odS, odZ;
    logic [3:0] ocA, ocS, ocZ, scS, scZ;
    logic [15:0] scA;
    logic ov[3], ir[3];
    logic [31:0] od[3];
    logic [3:0] oc[3];
    logic [15:0] sc[3];
    always_comb begin
        ov = '{ovA, ovS, ovZ};
        ir = '{irA, irS, irZ};
        od = '{odA, odS, odZ};
        oc = '{ocA, ocS, ocZ};
        sc = '{scA, {12'd0, scS}, {12'd0, scZ}};
    end

    pipe_stage_elastic dutA (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irA),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ovA), .out_ready(out_ready),
        .out_data(odA), .out_ctrl(ocA), .stall_cnt(scA));
    pipe_stage_elastic #(.CNT_W(4)) dutS (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irS),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ovS), .out_ready(out_ready),
        .out_data(odS), .out_ctrl(ocS), .stall_cnt(scS));
    pipe_stage_elastic #(.SKID(0), .CNT_W(4)) dutZ (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irZ),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ovZ), .out_ready(out_ready),
        .out_data(odZ), .out_ctrl(ocZ), .stall_cnt(scZ));

    int checks = 0, errors = 0;
    logic [35:0] mq[3][$];
    int mcnt[3];
    int cntMax[3] = '{65535, 15, 15};
    bit isSkid[3] = '{1'b1, 1'b1, 1'b0};

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    function automatic logic expReady(int i);
        return isSkid[i] ? (mq[i].size() < 2) : (out_ready || mq[i].size() == 0);
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
    endtask

    task automatic modelEdge();
        for (int i = 0; i < 3; i++) begin
            logic inF;
            inF = in_valid && expReady(i);
            if (mq[i].size() > 0 && !out_ready && mcnt[i] < cntMax[i]) mcnt[i]++;
            if (flush) mq[i].delete();
            else begin
                if (mq[i].size() > 0 && out_ready) void'(mq[i].pop_front());
                if (inF) mq[i].push_back({in_ctrl, in_data});
            end
        end
    endtask

    task automatic checkOuts();
        for (int i = 0; i < 3; i++) begin
            logic [35:0] h;
            h = (mq[i].size() > 0) ? mq[i][0] : 36'd0;
            chk("out_valid", i, 64'(ov[i]), 64'(mq[i].size() > 0));
            chk("out_ctrl", i, 64'(oc[i]), 64'(h[35:32]));
            if (mq[i].size() > 0) chk("out_data", i, 64'(od[i]), 64'(h[31:0]));
            chk("stall_cnt", i, 64'(sc[i]), 64'(mcnt[i]));
            chk("in_ready", i, 64'(ir[i]), 64'(expReady(i)));
        end
    endtask

    task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic [3:0] c, input logic ordy);
        @(negedge clk);
        flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        #1;
        for (int i = 0; i < 3; i++) chk("in_ready_comb", i, 64'(ir[i]), 64'(expReady(i)));
        @(posedge clk);
        modelEdge();
        #1;
        checkOuts();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        modelClear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOuts();
    endtask

    initial begin
        doReset();
        chk("rst_out_valid", 0, 64'(ovA), 64'd0);
        chk("rst_in_ready", 0, 64'(irA), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 32'(k), 4'h1, 1'b1);
            chk("stream_data", 0, 64'(odA), 64'(k));
            chk("stream_ready", 0, 64'(irA), 64'd1);
        end
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("stream_stall", 0, 64'(scA), 64'd0);
        step(1'b0, 1'b1, 32'hA, 4'h3, 1'b0);
        step(1'b0, 1'b1, 32'hB, 4'h5, 1'b0);
        chk("bp_full", 0, 64'(irA), 64'd0);
        repeat (3) step(1'b0, 1'b1, 32'hC, 4'h7, 1'b0);
        chk("bp_held", 0, 64'(odA), 64'hA);
        repeat (3) step(1'b0, 1'b1, 32'hC, 4'h7, 1'b1);
        repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);
        doReset();
        step(1'b0, 1'b1, 32'h11, 4'hF, 1'b0);
        step(1'b0, 1'b1, 32'h22, 4'hF, 1'b0);
        step(1'b1, 1'b1, 32'h33, 4'hF, 1'b0);
        chk("flush_valid", 0, 64'(ovA), 64'd0);
        chk("flush_ctrl", 0, 64'(ocA), 64'd0);
        chk("flush_ready", 0, 64'(irA), 64'd1);
        repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
        doReset();
        step(1'b0, 1'b1, 32'h44, 4'h2, 1'b0);
        repeat (20) step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("sat", 1, 64'(scS), 64'd15);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("sat_hold", 2, 64'(scZ), 64'd15);
        step(1'b0, 1'b1, 32'h55, 4'h9, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 modelClear();
        checkOuts();
        chk("async_data", 0, 64'(odA), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 checkOuts();
        repeat (400)
            step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 3) != 0);
        repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
